cache_miss_fill_fsm: RTL and testbench
======================================

Name: cache_miss_fill_fsm

Overview:
- Miss handler for the 2-way, 64-set, 8-word-per-block L1 cache array; sits directly upstream of the array and drives its write controls.
- On a miss, fetches the 8-word block from the pipelined main memory and writes each returned word into the victim way, bypassing it to the requester.
- Then rewrites both ways' metadata bytes: valid, LRU and tag.

Parameters:
- NUM_WORDS, 8: words per block; only 8 is supported.
- TAG_W, 6: tag bits; address split is tag[15:10], index[9:4], offset[3:0].

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-low reset.
- miss_detected  in  1  tag compare failed this cycle; sampled only in IDLE.
- miss_addr  in  16  byte address of the missing access; latched with miss_detected.
- victim_way  in  1  way to replace (0/1), from LRU bits; latched with miss_detected.
- other_meta  in  8  current metadata byte of the non-victim way; latched with miss_detected.
- mem_data_in  in  16  memory read data.
- mem_data_valid  in  1  mem_data_in valid this cycle.
- mem_en  out  1  memory read request.
- mem_addr  out  16  memory read address.
- cache_data  out  16  data to array data port.
- dataWE  out  1  data write enable.
- metaWE  out  1  metadata write enable.
- WordEnable  out  8  one-hot word select.
- blockSelect  out  64  one-hot set select, from the latched index.
- write0  out  1  way-0 select.
- write1  out  1  way-1 select.
- tag_out  out  8  metadata byte: {valid, lru, tag[5:0]}.
- miss  out  1  fill in progress; enables the array bypass.
- fsm_busy  out  1  handler active; the pipeline stalls on it.
- done  out  1  single-cycle fill-complete pulse.

Behaviour:
- Reset (rst=0, async): state IDLE, counters 0, all outputs 0 (blockSelect=0, WordEnable=0).
- States: IDLE, FILL, META_V, META_O, DONE.
- IDLE:
  - miss_detected=1 latches miss_addr, victim_way and other_meta; next state FILL.
  - mem_data_valid is ignored.
- FILL, request side:
  - issue_cnt (0..8) increments each cycle while below 8.
  - mem_en=1 while issue_cnt<8; mem_addr={tag,index,issue_cnt[2:0],1'b0}, i.e. words 0..7 in order.
  - Memory accepts one request per cycle with fixed latency; no backpressure.
- FILL, return side:
  - Each mem_data_valid drives cache_data=mem_data_in, dataWE=1, WordEnable=1<<recv_cnt, write0/write1 per the latched victim.
  - recv_cnt then increments.
  - When recv_cnt reaches 8 (after its final increment), next state META_V.
  - Issue and return may overlap in the same cycle.
- miss=1 and fsm_busy=1 in every state except IDLE.
- blockSelect=1<<index in all non-IDLE states.
- META_V (1 cycle): metaWE=1, victim way selected, tag_out={1,0,tag}.
- META_O (1 cycle): metaWE=1, other way selected, tag_out={other_meta[7],1,other_meta[5:0]}.
- DONE (1 cycle): done=1, fsm_busy=1; next state IDLE.
- In any cycle: dataWE and metaWE are never both 1; write0 and write1 are never both 1.
- miss_detected outside IDLE is ignored; no new fill starts until the cycle after DONE.
- A mem_data_valid after recv_cnt=8, or outside FILL, is ignored and not counted.
- Reset mid-fill returns to IDLE immediately. Memory returns still in flight are then discarded. The partially written block stays invalid because its metadata is never written.
- Memory latency L: mem_data_valid for word k arrives L cycles after its request.
  - Total fill from miss_detected to done = 1 + 8 + L + 2 + 1 cycles (minus overlap per the above).
  - Bench reference value for L=4: done asserts 15 cycles after the miss_detected cycle (±0).

Test Plan:
- Reset then miss_addr=0x1234, victim_way=0, L=4 → mem_addr 0x1230,0x1232…0x123E on 8 consecutive cycles. Index=0x23, so blockSelect bit 35 is set. Returned words hit WordEnable 0x01..0x80 with write0=1. META_V tag_out=0x84. done after 15 cycles.
- victim_way=1, other_meta=0x85 → META_O writes way 0 with tag_out=0xC5; META_V writes way 1.
- miss_detected pulsed during FILL with a different address → ignored; mem_addr sequence and latched index unchanged.
- Stray mem_data_valid in IDLE → no dataWE, recv_cnt stays 0.
- rst low after word 3 written → all outputs 0 the same cycle; no metaWE. Late returns are ignored. A new miss afterwards fills normally from word 0.
- Back-to-back misses, the second asserted in the DONE cycle → ignored. The second is accepted when reasserted in IDLE; fsm_busy low for exactly 1 cycle between fills.

Source files
------------

// File: rtl/cache_miss_fill_fsm.sv
// rtl/cache_miss_fill_fsm.sv - L1 miss handler: fetches an 8-word block into the victim way, then rewrites both ways' metadata
`timescale 1ns/1ps
module cache_miss_fill_fsm #(
  parameter int NUM_WORDS = 8,
  parameter int TAG_W     = 6
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        miss_detected,
  input  logic [15:0] miss_addr,
  input  logic        victim_way,
  input  logic [7:0]  other_meta,
  input  logic [15:0] mem_data_in,
  input  logic        mem_data_valid,
  output logic        mem_en,
  output logic [15:0] mem_addr,
  output logic [15:0] cache_data,
  output logic        dataWE,
  output logic        metaWE,
  output logic [7:0]  WordEnable,
  output logic [63:0] blockSelect,
  output logic        write0,
  output logic        write1,
  output logic [7:0]  tag_out,
  output logic        miss,
  output logic        fsm_busy,
  output logic        done
);

  typedef enum logic [2:0] {IDLE, FILL, META_V, META_O, DONE} stateT;

  localparam logic [3:0] WORDS = 4'(NUM_WORDS);

  stateT            stateQ, stateD;
  logic [3:0]       issueCnt, issueCntD;
  logic [3:0]       recvCnt, recvCntD;
  logic [TAG_W-1:0] tagQ, tagD;
  logic [5:0]       indexQ, indexD;
  logic             victimQ, victimD;
  logic [6:0]       otherMetaQ, otherMetaD;  // {valid, tag}; the stored LRU bit is always rewritten

  logic unusedBits;
  assign unusedBits = ^{miss_addr[3:0], other_meta[6]};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stateQ     <= IDLE;
      issueCnt   <= '0;
      recvCnt    <= '0;
      tagQ       <= '0;
      indexQ     <= '0;
      victimQ    <= 1'b0;
      otherMetaQ <= '0;
    end else begin
      stateQ     <= stateD;
      issueCnt   <= issueCntD;
      recvCnt    <= recvCntD;
      tagQ       <= tagD;
      indexQ     <= indexD;
      victimQ    <= victimD;
      otherMetaQ <= otherMetaD;
    end
  end

  always_comb begin
    stateD      = stateQ;
    issueCntD   = issueCnt;
    recvCntD    = recvCnt;
    tagD        = tagQ;
    indexD      = indexQ;
    victimD     = victimQ;
    otherMetaD  = otherMetaQ;
    mem_en      = 1'b0;
    mem_addr    = '0;
    cache_data  = '0;
    dataWE      = 1'b0;
    metaWE      = 1'b0;
    WordEnable  = '0;
    blockSelect = '0;
    write0      = 1'b0;
    write1      = 1'b0;
    tag_out     = '0;
    miss        = 1'b0;
    fsm_busy    = 1'b0;
    done        = 1'b0;

    if (stateQ != IDLE) begin
      miss        = 1'b1;
      fsm_busy    = 1'b1;
      blockSelect = 64'(1) << indexQ;
    end

    case (stateQ)
      IDLE: begin
        issueCntD = '0;
        recvCntD  = '0;
        if (miss_detected) begin
          tagD       = miss_addr[15 -: TAG_W];
          indexD     = miss_addr[9:4];
          victimD    = victim_way;
          otherMetaD = {other_meta[7], other_meta[5:0]};
          stateD     = FILL;
        end
      end
      FILL: begin
        // Requests stream out one per cycle; returns are written as they arrive.
        if (issueCnt < WORDS) begin
          mem_en    = 1'b1;
          mem_addr  = {tagQ, indexQ, issueCnt[2:0], 1'b0};
          issueCntD = issueCnt + 4'd1;
        end
        if (mem_data_valid && (recvCnt < WORDS)) begin
          cache_data = mem_data_in;
          dataWE     = 1'b1;
          WordEnable = 8'(1) << recvCnt[2:0];
          write0     = ~victimQ;
          write1     = victimQ;
          recvCntD   = recvCnt + 4'd1;
          if (recvCnt == WORDS - 4'd1) stateD = META_V;
        end
      end
      META_V: begin
        metaWE  = 1'b1;
        write0  = ~victimQ;
        write1  = victimQ;
        tag_out = {1'b1, 1'b0, tagQ};
        stateD  = META_O;
      end
      META_O: begin
        metaWE  = 1'b1;
        write0  = victimQ;
        write1  = ~victimQ;
        tag_out = {otherMetaQ[6], 1'b1, otherMetaQ[5:0]};
        stateD  = DONE;
      end
      DONE: begin
        done   = 1'b1;
        stateD = IDLE;
      end
      default: stateD = IDLE;
    endcase
  end

endmodule

// File: tb/tb_cache_miss_fill_fsm.sv
// tb/tb_cache_miss_fill_fsm.sv - self-checking bench for cache_miss_fill_fsm with a fixed-latency memory model
`timescale 1ns/1ps
module tb_cache_miss_fill_fsm;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        miss_detected = 1'b0;
  logic [15:0] miss_addr = '0;
  logic        victim_way = 1'b0;
  logic [7:0]  other_meta = '0;
  logic [15:0] mem_data_in = '0;
  logic        mem_data_valid = 1'b0;
  logic        mem_en, dataWE, metaWE, write0, write1, miss, fsm_busy, done;
  logic [15:0] mem_addr, cache_data;
  logic [7:0]  WordEnable, tag_out;
  logic [63:0] blockSelect;

  cache_miss_fill_fsm dut (
    .clk(clk), .rst(rst), .miss_detected(miss_detected), .miss_addr(miss_addr),
    .victim_way(victim_way), .other_meta(other_meta), .mem_data_in(mem_data_in),
    .mem_data_valid(mem_data_valid), .mem_en(mem_en), .mem_addr(mem_addr),
    .cache_data(cache_data), .dataWE(dataWE), .metaWE(metaWE), .WordEnable(WordEnable),
    .blockSelect(blockSelect), .write0(write0), .write1(write1), .tag_out(tag_out),
    .miss(miss), .fsm_busy(fsm_busy), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct { int due; logic [15:0] addr; } reqT;

  int  testCnt = 0, failCnt = 0, cyc = 0, lat = 4;
  reqT memQ[$];
  logic [7:0] metaLog[$];

  logic        drvRst = 1'b0, drvMiss = 1'b0, drvVictim = 1'b0, strayNext = 1'b0;
  logic [15:0] drvAddr = '0;
  logic [7:0]  drvOther = '0;

  // Reference model of the fill in progress, timed from the accepting cycle.
  bit          fillOn = 1'b0, fillVictim = 1'b0;
  int          fillStart = 0, fillLat = 0, fillRecv = 0;
  logic [15:0] fillBase = '0;
  logic [7:0]  fillOther = '0;
  int          obsDoneCyc = -1, lowRun = 0, lastGap = -1;

  function automatic logic [15:0] memWord(input logic [15:0] a);
    return 16'((a * 16'h2F1B) ^ 16'h5A3C);
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    testCnt++;
    assert (obs === exp) else begin
      failCnt++;
      $error("FAIL %s observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic checkOutputs();
    int r;
    bit act, expMemEn, expDataWE, metaV, metaO, expDone, expW0, expW1;
    logic [15:0] expAddr, expCache;
    logic [7:0]  expWE, expTag;
    logic [63:0] expBlk;
    if (!rst) fillOn = 1'b0;
    act       = fillOn;
    r         = fillOn ? cyc - fillStart : 0;
    expMemEn  = act && r >= 1 && r <= 8;
    expAddr   = expMemEn ? fillBase + 16'(2 * (r - 1)) : 16'h0;
    expDataWE = act && fillRecv < 8 && mem_data_valid;
    expCache  = expDataWE ? memWord(fillBase + 16'(2 * fillRecv)) : 16'h0;
    expWE     = expDataWE ? 8'(1) << fillRecv : 8'h0;
    metaV     = act && r == 9 + fillLat;
    metaO     = act && r == 10 + fillLat;
    expDone   = act && r == 11 + fillLat;
    expW0     = ((expDataWE || metaV) && !fillVictim) || (metaO && fillVictim);
    expW1     = ((expDataWE || metaV) && fillVictim) || (metaO && !fillVictim);
    expTag    = metaV ? {2'b10, fillBase[15:10]} :
                metaO ? {fillOther[7], 1'b1, fillOther[5:0]} : 8'h0;
    expBlk    = act ? 64'(1) << fillBase[9:4] : 64'h0;

    chk("mem_en",      64'(mem_en),      64'(expMemEn));
    chk("mem_addr",    64'(mem_addr),    64'(expAddr));
    chk("dataWE",      64'(dataWE),      64'(expDataWE));
    chk("cache_data",  64'(cache_data),  64'(expCache));
    chk("WordEnable",  64'(WordEnable),  64'(expWE));
    chk("metaWE",      64'(metaWE),      64'(metaV || metaO));
    chk("write0",      64'(write0),      64'(expW0));
    chk("write1",      64'(write1),      64'(expW1));
    chk("tag_out",     64'(tag_out),     64'(expTag));
    chk("blockSelect", blockSelect,      expBlk);
    chk("miss",        64'(miss),        64'(act));
    chk("fsm_busy",    64'(fsm_busy),    64'(act));
    chk("done",        64'(done),        64'(expDone));

    if (expDataWE) fillRecv++;
    if (act && expDone) begin
      fillOn = 1'b0;
    end else if (!act && rst && miss_detected) begin
      fillOn     = 1'b1;
      fillStart  = cyc;
      fillLat    = lat;
      fillBase   = miss_addr & 16'hFFF0;
      fillVictim = victim_way;
      fillOther  = other_meta;
      fillRecv   = 0;
    end
  endtask

  task automatic tick();
    reqT rq;
    @(posedge clk);
    cyc++;
    #1;
    rst            = drvRst;
    miss_detected  = drvMiss;
    miss_addr      = drvAddr;
    victim_way     = drvVictim;
    other_meta     = drvOther;
    mem_data_valid = 1'b0;
    mem_data_in    = 16'($urandom);
    if (memQ.size() > 0 && memQ[0].due == cyc) begin
      rq             = memQ.pop_front();
      mem_data_valid = 1'b1;
      mem_data_in    = memWord(rq.addr);
    end else if (strayNext) begin
      mem_data_valid = 1'b1;
      strayNext      = 1'b0;
    end
    #3;
    checkOutputs();
    if (mem_en) memQ.push_back('{due: cyc + lat, addr: mem_addr});
    if (metaWE) metaLog.push_back(tag_out);
    if (done) obsDoneCyc = cyc;
    if (!fsm_busy) lowRun++;
    else begin
      if (lowRun > 0) lastGap = lowRun;
      lowRun = 0;
    end
  endtask

  task automatic startFill(input logic [15:0] a, input logic v, input logic [7:0] om, input int l);
    lat        = l;
    drvMiss    = 1'b1;
    drvAddr    = a;
    drvVictim  = v;
    drvOther   = om;
    obsDoneCyc = -1;
    tick();
    drvMiss    = 1'b0;
  endtask

  task automatic finishFill();
    for (int i = 0; i < 60 && fillOn; i++) tick();
    chk("fill_terminates", 64'(fillOn), 64'(0));
  endtask

  initial begin
    // Reset state
    drvRst = 1'b0;
    repeat (3) tick();
    drvRst = 1'b1;
    repeat (2) tick();

    // Victim way 0, L=4, directed address
    metaLog.delete();
    startFill(16'h1234, 1'b0, 8'h00, 4);
    finishFill();
    chk("done_latency_L4", 64'(obsDoneCyc - fillStart), 64'(15));
    chk("metav_tag_0x84", 64'(metaLog.size() > 0 ? metaLog[0] : 8'hxx), 64'(8'h84));

    // Victim way 1, other way metadata rewritten with LRU set
    repeat (2) tick();
    metaLog.delete();
    startFill(16'h7A58, 1'b1, 8'h85, 4);
    finishFill();
    chk("metao_tag_0xC5", 64'(metaLog.size() > 1 ? metaLog[1] : 8'hxx), 64'(8'hC5));

    // Stray return in IDLE, then a fill with miss_detected pulsed mid-fill
    strayNext = 1'b1;
    repeat (2) tick();
    startFill(16'h4560, 1'($urandom), 8'($urandom), 4);
    repeat (3) tick();
    drvMiss = 1'b1;
    drvAddr = 16'hFFFE;
    repeat (2) tick();
    drvMiss = 1'b0;
    finishFill();

    // Randomized fills with varying memory latency
    for (int k = 0; k < 5; k++) begin
      int l;
      l = int'($urandom_range(1, 6));
      repeat (int'($urandom_range(1, 3))) tick();
      startFill(16'($urandom), 1'($urandom), 8'($urandom), l);
      finishFill();
      chk("done_latency", 64'(obsDoneCyc - fillStart), 64'(11 + l));
    end

    // Reset after word 3 written; late returns must be ignored
    tick();
    startFill(16'h9ABC, 1'b1, 8'hFF, 4);
    for (int i = 0; i < 40 && fillRecv < 4; i++) tick();
    chk("reached_word3", 64'(fillRecv), 64'(4));
    metaLog.delete();
    drvRst = 1'b0;
    repeat (2) tick();
    drvRst = 1'b1;
    for (int i = 0; i < 20 && memQ.size() > 0; i++) tick();
    tick();
    chk("no_meta_after_reset", 64'(metaLog.size()), 64'(0));
    startFill(16'h0C3E, 1'b0, 8'h41, 3);
    finishFill();

    // Back-to-back: miss held through DONE is only taken in the following IDLE cycle
    tick();
    startFill(16'h2F70, 1'b0, 8'h12, 4);
    for (int i = 0; i < 40 && fillOn && (cyc - fillStart) < 11 + fillLat - 1; i++) tick();
    drvMiss   = 1'b1;
    drvAddr   = 16'hD1E0;
    drvVictim = 1'b1;
    drvOther  = 8'h33;
    lastGap   = -1;
    tick();
    chk("done_cycle_seen", 64'(obsDoneCyc), 64'(cyc));
    tick();
    drvMiss = 1'b0;
    finishFill();
    chk("busy_gap", 64'(lastGap), 64'(1));
    chk("second_fill_base", 64'(fillBase), 64'(16'hD1E0));
    repeat (2) tick();

    $display("[TB] %0d tests run, %0d failed", testCnt, failCnt);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

endmodule
